// File: rtl/hpdcache_core_rsp_fifo.sv
// Purpose : response buffer from the refill handler (producer) to the core response port (consumer).
// Latency : 0 cycles through the empty-buffer bypass when FEEDTHROUGH=1, otherwise 1 cycle minimum.
// Backpr. : w_ready_o drops only when all DEPTH entries are stored; it never looks at r_ready_i.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   w_i/w_ready_o/wdata_i  producer valid/ready/payload
//   r_o/r_ready_i/rdata_o  consumer valid/ready/payload
//   usage_o              registered count of stored entries (bypassed payloads excluded)
//   max_usage_o          high-water mark of usage_o      (only with HPDCACHE_CORE_RSP_FIFO_STATS_EN)
//   stall_cnt_o          saturating producer stall count (only with HPDCACHE_CORE_RSP_FIFO_STATS_EN)
//
// Optional statistics are enabled by defining HPDCACHE_CORE_RSP_FIFO_STATS_EN.
module hpdcache_core_rsp_fifo #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter bit          FEEDTHROUGH = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,

  input  logic                         w_i,
  output logic                         w_ready_o,
  input  logic [DATA_WIDTH-1:0]        wdata_i,

  output logic                         r_o,
  input  logic                         r_ready_i,
  output logic [DATA_WIDTH-1:0]        rdata_o,

  output logic [$clog2(DEPTH+1)-1:0]   usage_o
`ifdef HPDCACHE_CORE_RSP_FIFO_STATS_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   max_usage_o,
  output logic [15:0]                  stall_cnt_o
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  // A single-entry buffer still needs a 1-bit pointer; it simply never leaves 0.
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic empty;
  logic full;
  logic bypass;
  logic push;
  logic pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // Ready is a pure function of occupancy so the producer never sees a
  // combinational path from the consumer's ready.
  assign w_ready_o = !full;

  // With feedthrough, a producer valid is visible to the consumer even when
  // nothing is stored; that is also why r_o follows w_i while in reset.
  assign r_o     = !empty || (FEEDTHROUGH && w_i);
  assign rdata_o = empty ? wdata_i : mem[rptr_q];

  // Bypass only ever happens on an empty buffer, so it cannot overtake a
  // stored response. A bypassed payload touches no state at all.
  assign bypass = FEEDTHROUGH && empty && w_i && r_ready_i;

  // A push is any accepted producer beat that was not consumed by the bypass.
  // A pop only takes from storage; the bypass consumer beat is not a pop.
  assign push = w_i && w_ready_o && !bypass;
  assign pop  = r_ready_i && !empty;

  // Pointers wrap by comparison so that non power-of-two depths work.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;

    if (push) begin
      wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
    end

    if (pop) begin
      rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; entries are only ever read after
  // being written, as guarded by count_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr_q] <= wdata_i;
    end
  end

  assign usage_o = count_q;

`ifdef HPDCACHE_CORE_RSP_FIFO_STATS_EN
  logic [CNT_W-1:0] max_usage_q;
  logic [15:0]      stall_cnt_q;

  // High-water mark follows the registered count, so it lags count by a cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      max_usage_q <= '0;
    end else if (count_q > max_usage_q) begin
      max_usage_q <= count_q;
    end
  end

  // A stall is a cycle where the producer offers a response the buffer cannot take.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (w_i && !w_ready_o && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign max_usage_o = max_usage_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hpdcache_core_rsp_fifo.sv
// Directed bench for hpdcache_core_rsp_fifo using three instances:
//   a: DEPTH=4, FEEDTHROUGH=1   b: DEPTH=4, FEEDTHROUGH=0   c: DEPTH=3, FEEDTHROUGH=0
module tb_hpdcache_core_rsp_fifo;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic          a_w, a_wr, a_r, a_rr;
  logic [DW-1:0] a_wd, a_rd;
  logic [2:0]    a_use;
  logic          b_w, b_wr, b_r, b_rr;
  logic [DW-1:0] b_wd, b_rd;
  logic [2:0]    b_use;
  logic          c_w, c_wr, c_r, c_rr;
  logic [DW-1:0] c_wd, c_rd;
  logic [1:0]    c_use;
`ifdef HPDCACHE_CORE_RSP_FIFO_STATS_EN
  logic [2:0]  a_max, b_max;
  logic [1:0]  c_max;
  logic [15:0] a_stall, b_stall, c_stall;
`endif

  hpdcache_core_rsp_fifo #(.DEPTH(4), .DATA_WIDTH(DW), .FEEDTHROUGH(1'b1)) u_a (
    .clk_i(clk), .rst_i(rst),
    .w_i(a_w), .w_ready_o(a_wr), .wdata_i(a_wd),
    .r_o(a_r), .r_ready_i(a_rr), .rdata_o(a_rd),
    .usage_o(a_use)
`ifdef HPDCACHE_CORE_RSP_FIFO_STATS_EN
    , .max_usage_o(a_max), .stall_cnt_o(a_stall)
`endif
  );

  hpdcache_core_rsp_fifo #(.DEPTH(4), .DATA_WIDTH(DW), .FEEDTHROUGH(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst),
    .w_i(b_w), .w_ready_o(b_wr), .wdata_i(b_wd),
    .r_o(b_r), .r_ready_i(b_rr), .rdata_o(b_rd),
    .usage_o(b_use)
`ifdef HPDCACHE_CORE_RSP_FIFO_STATS_EN
    , .max_usage_o(b_max), .stall_cnt_o(b_stall)
`endif
  );

  hpdcache_core_rsp_fifo #(.DEPTH(3), .DATA_WIDTH(DW), .FEEDTHROUGH(1'b0)) u_c (
    .clk_i(clk), .rst_i(rst),
    .w_i(c_w), .w_ready_o(c_wr), .wdata_i(c_wd),
    .r_o(c_r), .r_ready_i(c_rr), .rdata_o(c_rd),
    .usage_o(c_use)
`ifdef HPDCACHE_CORE_RSP_FIFO_STATS_EN
    , .max_usage_o(c_max), .stall_cnt_o(c_stall)
`endif
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if (a_use !== 3'd0) begin errors++; $display("FAIL reset_a_usage got %0d exp 0", a_use); end
    checks++; if (a_wr !== 1'b1) begin errors++; $display("FAIL reset_a_wready got %b exp 1", a_wr); end
    checks++; if (a_r !== 1'b0) begin errors++; $display("FAIL reset_a_r got %b exp 0", a_r); end
    checks++; if (b_use !== 3'd0) begin errors++; $display("FAIL reset_b_usage got %0d exp 0", b_use); end
    checks++; if (b_wr !== 1'b1) begin errors++; $display("FAIL reset_b_wready got %b exp 1", b_wr); end
    checks++; if (c_use !== 2'd0) begin errors++; $display("FAIL reset_c_usage got %0d exp 0", c_use); end
    a_w = 1'b1; b_w = 1'b1;
    #1;
    checks++; if (a_r !== 1'b1) begin errors++; $display("FAIL reset_a_r_follows_w got %b exp 1", a_r); end
    checks++; if (b_r !== 1'b0) begin errors++; $display("FAIL reset_b_r_no_ft got %b exp 0", b_r); end
    a_w = 1'b0; b_w = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_bypass();
    a_rr = 1'b1; a_w = 1'b1; a_wd = 16'h00A5;
    #1;
    checks++; if (a_r !== 1'b1) begin errors++; $display("FAIL bypass_r got %b exp 1", a_r); end
    checks++; if (a_rd !== 16'h00A5) begin errors++; $display("FAIL bypass_rdata got %h exp 00a5", a_rd); end
    tick();
    a_w = 1'b0;
    #1;
    checks++; if (a_use !== 3'd0) begin errors++; $display("FAIL bypass_usage got %0d exp 0", a_use); end
    checks++; if (a_r !== 1'b0) begin errors++; $display("FAIL bypass_r_after got %b exp 0", a_r); end
    // Feedthrough with consumer stalled: the payload must be stored.
    a_rr = 1'b0; a_w = 1'b1; a_wd = 16'h005A;
    #1;
    checks++; if (a_rd !== 16'h005A) begin errors++; $display("FAIL ft_stall_rdata got %h exp 005a", a_rd); end
    tick();
    a_w = 1'b0;
    #1;
    checks++; if (a_use !== 3'd1) begin errors++; $display("FAIL ft_stall_usage got %0d exp 1", a_use); end
    checks++; if (a_rd !== 16'h005A) begin errors++; $display("FAIL ft_stored_rdata got %h exp 005a", a_rd); end
    // Stored entry must win over a new producer beat.
    a_w = 1'b1; a_wd = 16'h0077; a_rr = 1'b1;
    #1;
    checks++; if (a_rd !== 16'h005A) begin errors++; $display("FAIL ft_order_rdata got %h exp 005a", a_rd); end
    tick();
    a_w = 1'b0;
    #1;
    checks++; if (a_use !== 3'd1) begin errors++; $display("FAIL ft_simul_usage got %0d exp 1", a_use); end
    checks++; if (a_rd !== 16'h0077) begin errors++; $display("FAIL ft_next_rdata got %h exp 0077", a_rd); end
    tick();
    a_rr = 1'b0;
    #1;
    checks++; if (a_use !== 3'd0) begin errors++; $display("FAIL ft_drain_usage got %0d exp 0", a_use); end
  endtask

  task automatic test_fill_drain();
    b_rr = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      b_w = 1'b1; b_wd = DW'(i);
      #1;
      if (i == 1) begin
        checks++; if (b_r !== 1'b0) begin errors++; $display("FAIL noft_empty_r got %b exp 0", b_r); end
      end
      checks++; if (b_wr !== 1'b1) begin errors++; $display("FAIL fill_wready_%0d got %b exp 1", i, b_wr); end
      tick();
    end
    b_w = 1'b0;
    #1;
    checks++; if (b_use !== 3'd4) begin errors++; $display("FAIL fill_usage got %0d exp 4", b_use); end
    checks++; if (b_wr !== 1'b0) begin errors++; $display("FAIL full_wready got %b exp 0", b_wr); end
    b_rr = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++; if (b_r !== 1'b1 || b_rd !== DW'(i)) begin errors++; $display("FAIL drain_%0d got r=%b d=%h exp r=1 d=%h", i, b_r, b_rd, DW'(i)); end
      tick();
    end
    b_rr = 1'b0;
    #1;
    checks++; if (b_use !== 3'd0) begin errors++; $display("FAIL drain_usage got %0d exp 0", b_use); end
    checks++; if (b_r !== 1'b0) begin errors++; $display("FAIL drain_r got %b exp 0", b_r); end
  endtask

  task automatic test_full_simul();
    b_rr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_w = 1'b1; b_wd = DW'(16'h0010 + i);
      tick();
    end
    b_w = 1'b1; b_wd = 16'h0014; b_rr = 1'b1;
    #1;
    checks++; if (b_wr !== 1'b0) begin errors++; $display("FAIL simul_wready got %b exp 0", b_wr); end
    checks++; if (b_rd !== 16'h0010) begin errors++; $display("FAIL simul_rdata got %h exp 0010", b_rd); end
    tick();
    b_rr = 1'b0;
    #1;
    checks++; if (b_use !== 3'd3) begin errors++; $display("FAIL simul_usage3 got %0d exp 3", b_use); end
    checks++; if (b_wr !== 1'b1) begin errors++; $display("FAIL simul_wready_back got %b exp 1", b_wr); end
    tick();
    b_w = 1'b0;
    #1;
    checks++; if (b_use !== 3'd4) begin errors++; $display("FAIL simul_usage4 got %0d exp 4", b_use); end
    b_rr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (b_rd !== DW'(16'h0011 + k)) begin errors++; $display("FAIL simul_drain_%0d got %h exp %h", k, b_rd, DW'(16'h0011 + k)); end
      tick();
    end
    b_rr = 1'b0;
    #1;
  endtask

  task automatic test_wrap();
    // 1 = push only, 2 = pop only, 3 = push and pop; occupancy stays within 1..3.
    int ops [14] = '{1, 1, 3, 3, 1, 2, 3, 3, 1, 2, 3, 2, 3, 2};
    logic [DW-1:0] q [$];
    int n = 0;
    for (int i = 0; i < 14; i++) begin
      c_w  = (ops[i] & 1) != 0;
      c_rr = (ops[i] & 2) != 0;
      c_wd = DW'(16'h00C0 + n);
      #1;
      checks++; if (c_wr !== (q.size() != 3)) begin errors++; $display("FAIL wrap_wready_%0d got %b exp %b", i, c_wr, (q.size() != 3)); end
      if (c_rr) begin
        checks++; if (c_r !== 1'b1 || c_rd !== q[0]) begin errors++; $display("FAIL wrap_pop_%0d got r=%b d=%h exp r=1 d=%h", i, c_r, c_rd, q[0]); end
      end
      tick();
      if (c_rr) void'(q.pop_front());
      if (c_w) begin q.push_back(c_wd); n++; end
      c_w = 1'b0; c_rr = 1'b0;
      #1;
      checks++; if (c_use !== 2'(q.size())) begin errors++; $display("FAIL wrap_usage_%0d got %0d exp %0d", i, c_use, q.size()); end
    end
    checks++; if (c_r !== 1'b0) begin errors++; $display("FAIL wrap_end_r got %b exp 0", c_r); end
  endtask

  task automatic test_reset_mid();
    b_rr = 1'b0; b_w = 1'b1; b_wd = 16'h0021;
    tick();
    b_wd = 16'h0022;
    tick();
    b_w = 1'b0;
    #1;
    checks++; if (b_use !== 3'd2) begin errors++; $display("FAIL rstmid_pre_usage got %0d exp 2", b_use); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (b_use !== 3'd0) begin errors++; $display("FAIL rstmid_usage got %0d exp 0", b_use); end
    checks++; if (b_wr !== 1'b1) begin errors++; $display("FAIL rstmid_wready got %b exp 1", b_wr); end
    checks++; if (b_r !== 1'b0) begin errors++; $display("FAIL rstmid_r got %b exp 0", b_r); end
    tick();
    rst = 1'b0;
    b_w = 1'b1; b_wd = 16'h0031;
    #1;
    checks++; if (b_r !== 1'b0) begin errors++; $display("FAIL rstmid_post_r got %b exp 0", b_r); end
    tick();
    b_wd = 16'h0032;
    tick();
    b_w = 1'b0; b_rr = 1'b1;
    #1;
    checks++; if (b_rd !== 16'h0031) begin errors++; $display("FAIL rstmid_first got %h exp 0031", b_rd); end
    tick();
    #1;
    checks++; if (b_rd !== 16'h0032) begin errors++; $display("FAIL rstmid_second got %h exp 0032", b_rd); end
    tick();
    b_rr = 1'b0;
    #1;
    checks++; if (b_use !== 3'd0) begin errors++; $display("FAIL rstmid_end_usage got %0d exp 0", b_use); end
  endtask

`ifdef HPDCACHE_CORE_RSP_FIFO_STATS_EN
  task automatic test_stats();
    b_rr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_w = 1'b1; b_wd = DW'(16'h0040 + i);
      tick();
    end
    checks++; if (b_stall !== 16'd0) begin errors++; $display("FAIL stats_stall0 got %0d exp 0", b_stall); end
    b_wd = 16'h0099;
    repeat (5) tick();
    checks++; if (b_stall !== 16'd5) begin errors++; $display("FAIL stats_stall5 got %0d exp 5", b_stall); end
    checks++; if (b_max !== 3'd4) begin errors++; $display("FAIL stats_max got %0d exp 4", b_max); end
    repeat (70000) tick();
    checks++; if (b_stall !== 16'hFFFF) begin errors++; $display("FAIL stats_sat got %h exp ffff", b_stall); end
    b_w = 1'b0;
  endtask
`endif

  initial begin
    a_w = 1'b0; a_rr = 1'b0; a_wd = '0;
    b_w = 1'b0; b_rr = 1'b0; b_wd = '0;
    c_w = 1'b0; c_rr = 1'b0; c_wd = '0;
    test_reset();
    test_bypass();
    test_fill_drain();
    test_full_simul();
    test_wrap();
    test_reset_mid();
`ifdef HPDCACHE_CORE_RSP_FIFO_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hpdcache_core_rsp_fifo.md
Name: hpdcache_core_rsp_fifo

Overview:
Response buffer between the HPDcache refill handler (producer) and the core response port (consumer). Stores refill/core responses in a circular buffer of DEPTH entries. When FEEDTHROUGH=1 (driven from the refill-core-rsp feedthrough cache parameter), a response arriving at an empty buffer passes combinationally to the core in the same cycle. Sits directly downstream of the refill handler and upstream of the core response mux.

Parameters:
DEPTH, 4, number of buffer entries; legal range 1..64; need not be a power of 2
DATA_WIDTH, 64, width of the response payload (word data + transaction ID + source ID + error bit, packed by the instantiator)
FEEDTHROUGH, 1'b1, 1 = empty-buffer bypass enabled; 0 = minimum one-cycle latency

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  asynchronous, active-high reset
w_i  input  1  producer valid
w_ready_o  output  1  producer ready
wdata_i  input  DATA_WIDTH  producer payload
r_o  output  1  consumer valid
r_ready_i  input  1  consumer ready
rdata_o  output  DATA_WIDTH  consumer payload
usage_o  output  $clog2(DEPTH+1)  current occupancy (stored entries only)

Behaviour:
- Reset (async assert, released synchronously with clk_i): rptr=0, wptr=0, count=0. Outputs during reset: r_o=0 if FEEDTHROUGH=0, else r_o follows w_i; w_ready_o=1; usage_o=0. The storage array is not reset. Reset asserted mid-transfer discards all stored entries. No response is produced for those entries.
- Handshakes: a push occurs when w_i && w_ready_o; a pop occurs when r_o && r_ready_i.
- Valid/data must stay stable until accepted on both sides. The FIFO never retracts r_o without a pop.
- w_ready_o = (count != DEPTH). This signal is combinational from state only and never depends on r_ready_i.
- r_o = (count != 0) || (FEEDTHROUGH && w_i).
- rdata_o = mem[rptr] if count != 0, else wdata_i (bypass path).
- Bypass: if FEEDTHROUGH && count==0 && w_i && r_ready_i, the payload goes directly to the consumer. Nothing is written; pointers and count are unchanged. Latency is 0 cycles.
- If FEEDTHROUGH && count==0 && w_i && !r_ready_i, the payload is written at wptr. Next cycle, count=1.
- Normal write: mem[wptr] <= wdata_i; wptr advances; wraps DEPTH-1 -> 0 by compare, not by modulo power of 2.
- Normal read: rptr advances with the same wrap rule.
- Simultaneous push and pop with 0 < count < DEPTH: both pointers advance and count is unchanged.
- Simultaneous push and pop with count == DEPTH: no push, because w_ready_o=0; pop only.
- Full: count==DEPTH, w_ready_o=0; w_i is held by the producer.
- Empty with FEEDTHROUGH=0: r_o=0; the first payload appears on the cycle after the push.
- Order: strict FIFO. A bypassed entry is never reordered ahead of stored entries, because bypass requires count==0.
- usage_o = count, registered; it excludes bypassed payloads.

Optional Feature:
Macro HPDCACHE_CORE_RSP_FIFO_STATS_EN.
When defined, two extra output ports are present:
- max_usage_o [$clog2(DEPTH+1)]: registered high-water mark of count; reset 0; updates the cycle after count exceeds it.
- stall_cnt_o [16]: increments each cycle w_i && !w_ready_o; saturates at 16'hFFFF; reset 0.
When undefined, these ports and their registers do not exist, and behaviour is otherwise identical.

Test Plan:
- FEEDTHROUGH=1, empty, r_ready_i=1, push wdata_i=0xA5 -> r_o=1 and rdata_o=0xA5 in the same cycle; usage_o stays 0.
- FEEDTHROUGH=0, DEPTH=4, r_ready_i=0, push 0x1,0x2,0x3,0x4 -> usage_o=4 and w_ready_o=0. Then r_ready_i=1 -> pops 0x1..0x4 in order over 4 cycles; usage_o ends at 0.
- DEPTH=3 wrap: 10 pushes interleaved with pops, occupancy 1..3 -> output sequence equals input sequence; wptr and rptr wrap 2->0 with no entry lost.
- Full plus simultaneous: count=4, w_i=1 and r_ready_i=1 -> exactly one pop, no push. The next cycle accepts the push; usage_o goes 4->3->4.
- Reset mid-operation: count=2, assert rst_i asynchronously between edges -> usage_o=0 and w_ready_o=1 immediately. With FEEDTHROUGH=0, r_o=0. After release, the first pushed payload is the first popped.
- STATS_EN: hold w_i=1 while full for 5 cycles -> stall_cnt_o=5 and max_usage_o=DEPTH. Forcing 70000 stall cycles -> stall_cnt_o=16'hFFFF.
